// File: rtl/l1a_check_sequencer.sv
// Sequencer for the 16-ADC L1A alignment checker: arm, check, result, holdoff.
// Define L1A_CHK_TIMEOUT_EN to enable the CHECK-state timeout and its statistics.
module l1a_check_sequencer #(
   parameter int NUM_ADC        = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int CNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run_en,
   input  logic               clear_stats,
   input  logic [NUM_ADC-1:0] trig_in,
   input  logic               one_adc_finish_check,
   input  logic               L1A_align,
   input  logic [NUM_ADC-1:0] error,
   output logic               chk_reset,
   output logic               check_in_progress,
   output logic [NUM_ADC-1:0] start_check,
   output logic               busy,
   output logic               result_valid,
   output logic               result_ok,
   output logic               result_timeout,
   output logic [NUM_ADC-1:0] result_error,
   output logic [CNT_W-1:0]   check_count,
   output logic [CNT_W-1:0]   fail_count,
   output logic [CNT_W-1:0]   timeout_count,
   output logic               sticky_fail
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_TRIG,
      CHECK,
      DONE,
      HOLDOFF
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

   state_t     state;
   logic [4:0] fin_cnt;
   logic [4:0] fin_next;
   logic [7:0] hold_cnt;
   logic       align_q;
   logic       align_now;
   logic       all_done;
   logic       tmo_hit;
   logic       done_evt;
   logic       ok_now;
   logic       unused_trig;

   assign unused_trig = ^trig_in[NUM_ADC-1:1];

`ifdef L1A_CHK_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0]      tmo_cnt;
   logic             res_tmo_q;
   logic [CNT_W-1:0] tmo_count_q;

   assign tmo_hit        = (tmo_cnt == TMO_LAST);
   assign result_timeout = res_tmo_q;
   assign timeout_count  = tmo_count_q;
`else
   localparam int unused_tmo = TIMEOUT_CYCLES;

   assign tmo_hit        = 1'b0;
   assign result_timeout = 1'b0;
   assign timeout_count  = '0;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A finish pulse on the expiry cycle counts before the timeout.
   always_comb begin
      fin_next  = fin_cnt + 5'(one_adc_finish_check);
      all_done  = (fin_next == 5'd16);
      align_now = align_q | L1A_align;
      ok_now    = align_now & all_done;
      done_evt  = (state == CHECK) && run_en
                  && (all_done || tmo_hit);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         fin_cnt           <= '0;
         hold_cnt          <= '0;
         align_q           <= 1'b0;
         chk_reset         <= 1'b1;
         check_in_progress <= 1'b0;
         start_check       <= '0;
         busy              <= 1'b0;
         result_valid      <= 1'b0;
         result_ok         <= 1'b0;
         result_error      <= '0;
`ifdef L1A_CHK_TIMEOUT_EN
         tmo_cnt           <= '0;
         res_tmo_q         <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (run_en) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               fin_cnt           <= '0;
               align_q           <= 1'b0;
`ifdef L1A_CHK_TIMEOUT_EN
               tmo_cnt           <= '0;
`endif
               state             <= WAIT_TRIG;
               chk_reset         <= 1'b0;
               check_in_progress <= 1'b1;
               start_check       <= '1;
            end
            WAIT_TRIG: begin
               if (!run_en) begin
                  state             <= IDLE;
                  busy              <= 1'b0;
                  chk_reset         <= 1'b1;
                  check_in_progress <= 1'b0;
                  start_check       <= '0;
               end else if (trig_in[0]) begin
                  state   <= CHECK;
                  fin_cnt <= fin_next;
               end
            end
            CHECK: begin
               if (!run_en) begin
                  state             <= IDLE;
                  busy              <= 1'b0;
                  chk_reset         <= 1'b1;
                  check_in_progress <= 1'b0;
                  start_check       <= '0;
               end else begin
                  fin_cnt <= fin_next;
                  align_q <= align_now;
`ifdef L1A_CHK_TIMEOUT_EN
                  tmo_cnt <= tmo_cnt + 16'd1;
`endif
                  if (all_done || tmo_hit) begin
                     state             <= DONE;
                     result_valid      <= 1'b1;
                     result_ok         <= ok_now;
                     result_error      <= error;
`ifdef L1A_CHK_TIMEOUT_EN
                     res_tmo_q         <= ~all_done;
`endif
                     chk_reset         <= 1'b1;
                     check_in_progress <= 1'b0;
                     start_check       <= '0;
                  end
               end
            end
            DONE: begin
               state    <= HOLDOFF;
               hold_cnt <= '0;
            end
            HOLDOFF: begin
               if (hold_cnt == HOLD_LAST) begin
                  if (run_en) begin
                     state <= ARM;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Statistics: clear_stats has priority over a coincident completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         check_count <= '0;
         fail_count  <= '0;
         sticky_fail <= 1'b0;
`ifdef L1A_CHK_TIMEOUT_EN
         tmo_count_q <= '0;
`endif
      end else if (clear_stats) begin
         check_count <= '0;
         fail_count  <= '0;
         sticky_fail <= 1'b0;
`ifdef L1A_CHK_TIMEOUT_EN
         tmo_count_q <= '0;
`endif
      end else if (done_evt) begin
         check_count <= sat_inc(check_count);
         if (!ok_now) begin
            fail_count  <= sat_inc(fail_count);
            sticky_fail <= 1'b1;
         end
`ifdef L1A_CHK_TIMEOUT_EN
         if (!all_done) begin
            tmo_count_q <= sat_inc(tmo_count_q);
         end
`endif
      end
   end

endmodule
